// File: rtl/branch_resolve_pkg.sv
// Shared types for the execute-stage branch resolution unit.
//   cmp_op_t    : compare operation selector driven into the compare unit
//   ctl_kind_t  : control-flow instruction kind offered by issue
//   brs_state_t : resolution FSM states
//   F3_*        : RV32I branch funct3 encodings
package branch_resolve_pkg;

  typedef enum logic [2:0] {
    CMP_EQ  = 3'd0,
    CMP_NE  = 3'd1,
    CMP_LT  = 3'd2,
    CMP_GE  = 3'd3,
    CMP_LTU = 3'd4,
    CMP_GEU = 3'd5
  } cmp_op_t;

  typedef enum logic [1:0] {
    KIND_NONE   = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_JAL    = 2'd2,
    KIND_JALR   = 2'd3
  } ctl_kind_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    SQUASH   = 2'd2
  } brs_state_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_compare.sv
// Combinational compare unit: evaluates a_i <op> b_i.
//   op_i     : cmp_op_t selector
//   a_i, b_i : operands (XLEN)
//   result_o : 1 when the relation holds
module branch_compare
  import branch_resolve_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  cmp_op_t           op_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  output logic              result_o
);

  always_comb begin
    result_o = 1'b0;
    unique case (op_i)
      CMP_EQ:  result_o = (a_i == b_i);
      CMP_NE:  result_o = (a_i != b_i);
      CMP_LT:  result_o = ($signed(a_i) <  $signed(b_i));
      CMP_GE:  result_o = ($signed(a_i) >= $signed(b_i));
      CMP_LTU: result_o = (a_i <  b_i);
      CMP_GEU: result_o = (a_i >= b_i);
      default: result_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_op_decode.sv
// Branch funct3 decoder.
//   funct3_i  : instruction funct3 field
//   op_o      : compare operation for the compare unit
//   illegal_o : funct3 has no branch meaning (010/011)
module branch_op_decode
  import branch_resolve_pkg::*;
(
  input  logic [2:0] funct3_i,
  output cmp_op_t    op_o,
  output logic       illegal_o
);

  always_comb begin
    op_o      = CMP_EQ;
    illegal_o = 1'b0;
    unique case (funct3_i)
      F3_BEQ:  op_o = CMP_EQ;
      F3_BNE:  op_o = CMP_NE;
      F3_BLT:  op_o = CMP_LT;
      F3_BGE:  op_o = CMP_GE;
      F3_BLTU: op_o = CMP_LTU;
      F3_BGEU: op_o = CMP_GEU;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution unit (RV32I).
// Resolves BRANCH/JAL/JALR against the fetch prediction, issues a held
// redirect on mispredict, then marks SQUASH_CYCLES wrong-path slots.
//   clk, rst_n            : clock, async active-low reset
//   in_*                  : issue handshake and operands
//   res_*                 : registered one-cycle result
//   redirect_*            : held fetch redirect, valid/ready handshake
//   squash                : current in_valid is wrong-path
//   stat_* (BRANCH_STATS_EN only): saturating evaluated/redirect counters
//
// state    | meaning
// IDLE     | evaluating offered instructions
// REDIRECT | holding redirect until fetch accepts, input stalled
// SQUASH   | consuming wrong-path inputs without evaluation
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_kind,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic            in_pred_taken,
  input  logic [XLEN-1:0] in_pred_target,
  output logic            res_valid,
  output logic            res_taken,
  output logic [XLEN-1:0] res_link,
  output logic            res_illegal,
  output logic            res_misalign,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts,
`endif
  output logic            squash
);

  localparam int CNT_W = 4;

  brs_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            res_valid_q, res_taken_q, res_illegal_q, res_misalign_q;
  logic [XLEN-1:0] res_link_q, rpc_q;

  cmp_op_t         cmp_op;
  logic            f3_illegal, cmp_result;
  logic            eval, is_branch, is_jump, illegal, taken, misalign;
  logic            mispredict, do_redirect;
  logic [XLEN-1:0] target, link, jalr_sum;

  branch_op_decode u_decode (
    .funct3_i  (in_funct3),
    .op_o      (cmp_op),
    .illegal_o (f3_illegal)
  );

  branch_compare #(.XLEN(XLEN)) u_compare (
    .op_i     (cmp_op),
    .a_i      (in_rs1),
    .b_i      (in_rs2),
    .result_o (cmp_result)
  );

  // Only IDLE evaluates; SQUASH accepts but discards, REDIRECT stalls.
  assign eval      = in_valid && (state_q == IDLE);
  assign is_branch = (in_kind == KIND_BRANCH);
  assign is_jump   = (in_kind == KIND_JAL) || (in_kind == KIND_JALR);
  assign illegal   = is_branch && f3_illegal;
  assign taken     = (is_branch && cmp_result && !illegal) || is_jump;

  assign jalr_sum  = in_rs1 + in_imm;
  assign target    = (in_kind == KIND_JALR) ? {jalr_sum[XLEN-1:1], 1'b0}
                                            : in_pc + in_imm;
  assign link      = in_pc + XLEN'(4);
  assign misalign  = taken && (target[1:0] != 2'b00);

  assign mispredict  = (taken != in_pred_taken) ||
                       (taken && (target != in_pred_target));
  assign do_redirect = eval && mispredict && !illegal && !misalign;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (do_redirect) state_d = REDIRECT;
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = SQUASH;
          cnt_d   = CNT_W'(SQUASH_CYCLES);
        end
      end
      SQUASH: begin
        if (in_valid) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      res_valid_q    <= 1'b0;
      res_taken_q    <= 1'b0;
      res_illegal_q  <= 1'b0;
      res_misalign_q <= 1'b0;
      res_link_q     <= '0;
      rpc_q          <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_valid_q <= eval;
      if (eval) begin
        res_taken_q    <= taken;
        res_illegal_q  <= illegal;
        res_misalign_q <= misalign;
        res_link_q     <= is_jump ? link : '0;
      end
      if (do_redirect) rpc_q <= taken ? target : link;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (eval && (in_kind != KIND_NONE) && (stat_br_q != '1))
        stat_br_q <= stat_br_q + 32'd1;
      if (do_redirect && (stat_mp_q != '1))
        stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

  assign in_ready       = (state_q != REDIRECT);
  assign squash         = (state_q == SQUASH);
  assign redirect_valid = (state_q == REDIRECT);
  // Gate the held PC so it reads 0 whenever no redirect is pending.
  assign redirect_pc    = redirect_valid ? rpc_q : '0;

  assign res_valid    = res_valid_q;
  assign res_taken    = res_taken_q;
  assign res_link     = res_link_q;
  assign res_illegal  = res_illegal_q;
  assign res_misalign = res_misalign_q;

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

  localparam int SQ = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  in_kind;
  logic [2:0]  in_funct3;
  logic [31:0] in_pc, in_imm, in_rs1, in_rs2, in_pred_target;
  logic        in_pred_taken;
  logic        res_valid, res_taken, res_illegal, res_misalign;
  logic [31:0] res_link, redirect_pc;
  logic        redirect_valid, redirect_ready, squash;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_resolve #(.XLEN(32), .SQUASH_CYCLES(SQ)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_kind        (in_kind),
    .in_funct3      (in_funct3),
    .in_pc          (in_pc),
    .in_imm         (in_imm),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_pred_taken  (in_pred_taken),
    .in_pred_target (in_pred_target),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .res_link       (res_link),
    .res_illegal    (res_illegal),
    .res_misalign   (res_misalign),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
`ifdef BRANCH_STATS_EN
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts),
`endif
    .squash         (squash)
  );

  localparam logic [1:0] K_NONE = 2'd0, K_BR = 2'd1, K_JAL = 2'd2, K_JALR = 2'd3;

  typedef struct {
    string       name;
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic [31:0] pc, imm, rs1, rs2;
    logic        pt;
    logic [31:0] ptgt;
    logic        e_taken, e_ill, e_mis;
    logic [31:0] e_link;
    logic        e_redir;
    logic [31:0] e_rpc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] r1, input logic [31:0] r2,
                       input logic pt, input logic [31:0] ptgt);
    in_kind = k; in_funct3 = f3; in_pc = pc; in_imm = imm;
    in_rs1 = r1; in_rs2 = r2; in_pred_taken = pt; in_pred_target = ptgt;
  endtask

  // Called one step after the edge where the redirect was accepted.
  task automatic squash_phase(input string nm);
    chk1({nm, " squash_on"}, squash, 1'b1);
    chk1({nm, " redir_drop"}, redirect_valid, 1'b0);
    chk1({nm, " sq_ready"}, in_ready, 1'b1);
    for (int i = 0; i < SQ; i++) begin
      // A JAL predicted not-taken would redirect if it were evaluated.
      drive(K_JAL, 3'b000, 32'h0000_5000, 32'h0000_0100, 32'h0, 32'h0, 1'b0, 32'h0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk1({nm, " sq_no_res"}, res_valid, 1'b0);
      chk1({nm, " sq_flag"}, squash, (i < SQ - 1));
      chk1({nm, " sq_no_redir"}, redirect_valid, 1'b0);
    end
    in_valid = 1'b0;
    chk1({nm, " idle_ready"}, in_ready, 1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    drive(v.kind, v.f3, v.pc, v.imm, v.rs1, v.rs2, v.pt, v.ptgt);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk1 ({v.name, " res_valid"}, res_valid, 1'b1);
    chk1 ({v.name, " taken"}, res_taken, v.e_taken);
    chk1 ({v.name, " illegal"}, res_illegal, v.e_ill);
    chk1 ({v.name, " misalign"}, res_misalign, v.e_mis);
    chk32({v.name, " link"}, res_link, v.e_link);
    chk1 ({v.name, " redir_valid"}, redirect_valid, v.e_redir);
    if (v.e_redir) begin
      chk32({v.name, " redir_pc"}, redirect_pc, v.e_rpc);
      chk1 ({v.name, " ready_low"}, in_ready, 1'b0);
      redirect_ready = 1'b1;
      @(posedge clk); #1;
      redirect_ready = 1'b0;
      squash_phase(v.name);
    end else begin
      chk1({v.name, " ready_high"}, in_ready, 1'b1);
      @(posedge clk); #1;
      chk1({v.name, " res_drop"}, res_valid, 1'b0);
      chk1({v.name, " no_redir"}, redirect_valid, 1'b0);
    end
  endtask

  task automatic add(input string nm, input logic [1:0] k, input logic [2:0] f3,
                     input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] r1,
                     input logic [31:0] r2, input logic pt, input logic [31:0] ptgt,
                     input logic et, input logic ei, input logic em, input logic [31:0] el,
                     input logic er, input logic [31:0] erpc);
    vec_t v;
    v.name = nm; v.kind = k; v.f3 = f3; v.pc = pc; v.imm = imm; v.rs1 = r1; v.rs2 = r2;
    v.pt = pt; v.ptgt = ptgt; v.e_taken = et; v.e_ill = ei; v.e_mis = em; v.e_link = el;
    v.e_redir = er; v.e_rpc = erpc;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //   name        kind    f3      pc            imm           rs1           rs2           pt    ptgt          tk ill mis link          rd  rpc
    add("beq_hit",   K_BR,   3'b000, 32'h100,      32'h20,       32'h5,        32'h5,        1'b1, 32'h120,      1, 0, 0, 32'h0,        0, 32'h0);
    add("bgeu_mp",   K_BR,   3'b111, 32'h300,      32'h10,       32'h7FFFFFFF, 32'h80000000, 1'b1, 32'h310,      0, 0, 0, 32'h0,        1, 32'h304);
    add("jalr_mis",  K_JALR, 3'b000, 32'h400,      32'h2,        32'h1001,     32'h0,        1'b1, 32'h1002,     1, 0, 1, 32'h404,      0, 32'h0);
    add("jalr_ok",   K_JALR, 3'b000, 32'h400,      32'h3,        32'h1001,     32'h0,        1'b1, 32'h1004,     1, 0, 0, 32'h404,      0, 32'h0);
    add("f3_010",    K_BR,   3'b010, 32'h500,      32'h8,        32'h1,        32'h1,        1'b1, 32'h508,      0, 1, 0, 32'h0,        0, 32'h0);
    add("jal_wrap",  K_JAL,  3'b000, 32'hFFFFFFFC, 32'h8,        32'h0,        32'h0,        1'b0, 32'h0,        1, 0, 0, 32'h0,        1, 32'h4);
    add("bne_nt",    K_BR,   3'b001, 32'h600,      32'h10,       32'h3,        32'h3,        1'b0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0);
    add("bge_neg",   K_BR,   3'b101, 32'h700,      32'h10,       32'h80000000, 32'h0,        1'b0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0);
    add("bltu_tgt",  K_BR,   3'b110, 32'h600,      32'h10,       32'h1,        32'hFFFFFFFF, 1'b1, 32'h700,      1, 0, 0, 32'h0,        1, 32'h610);
    add("none",      K_NONE, 3'b000, 32'h800,      32'h10,       32'h0,        32'h0,        1'b0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0);
    add("jalr_mp",   K_JALR, 3'b000, 32'h900,      32'h11,       32'h2000,     32'h0,        1'b0, 32'h0,        1, 0, 0, 32'h904,      1, 32'h2010);
    add("f3_011",    K_BR,   3'b011, 32'hA00,      32'h8,        32'h2,        32'h2,        1'b0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0);

    rst_n = 1'b0; in_valid = 1'b0; redirect_ready = 1'b0;
    drive(K_NONE, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    chk1 ("rst in_ready", in_ready, 1'b1);
    chk1 ("rst res_valid", res_valid, 1'b0);
    chk1 ("rst redirect_valid", redirect_valid, 1'b0);
    chk32("rst redirect_pc", redirect_pc, 32'h0);
    chk1 ("rst squash", squash, 1'b0);
    chk32("rst res_link", res_link, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // redirect_ready while IDLE has no effect
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    chk1("idle rr squash", squash, 1'b0);
    chk1("idle rr redir", redirect_valid, 1'b0);
    chk1("idle rr ready", in_ready, 1'b1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // BLT mispredict with fetch stalling the redirect for 3 cycles
    drive(K_BR, 3'b100, 32'h200, 32'h40, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    chk1 ("blt taken", res_taken, 1'b1);
    chk1 ("blt redir", redirect_valid, 1'b1);
    chk32("blt redir_pc", redirect_pc, 32'h240);
    drive(K_JAL, 3'b000, 32'h7000, 32'h80, 32'h0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk1 ("blt hold valid", redirect_valid, 1'b1);
      chk32("blt hold pc", redirect_pc, 32'h240);
      chk1 ("blt hold ready", in_ready, 1'b0);
      chk1 ("blt hold no_res", res_valid, 1'b0);
    end
    in_valid = 1'b0;
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    squash_phase("blt");

    // Reset asserted while a redirect is pending
    drive(K_JAL, 3'b000, 32'h1000, 32'h100, 32'h0, 32'h0, 1'b0, 32'h0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk1("rstmid pre redir", redirect_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk1 ("rstmid redir", redirect_valid, 1'b0);
    chk32("rstmid redir_pc", redirect_pc, 32'h0);
    chk1 ("rstmid ready", in_ready, 1'b1);
    chk1 ("rstmid res_valid", res_valid, 1'b0);
    chk1 ("rstmid res_taken", res_taken, 1'b0);
    chk32("rstmid res_link", res_link, 32'h0);
    chk1 ("rstmid squash", squash, 1'b0);
`ifdef BRANCH_STATS_EN
    chk32("rstmid stat_br", stat_branches, 32'h0);
    chk32("rstmid stat_mp", stat_mispredicts, 32'h0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    begin
      vec_t v;
      v.name = "post_rst"; v.kind = K_BR; v.f3 = 3'b000; v.pc = 32'h1200; v.imm = 32'h40;
      v.rs1 = 32'h1; v.rs2 = 32'h2; v.pt = 1'b0; v.ptgt = 32'h0;
      v.e_taken = 1'b0; v.e_ill = 1'b0; v.e_mis = 1'b0; v.e_link = 32'h0;
      v.e_redir = 1'b0; v.e_rpc = 32'h0;
      run_vec(v);
    end
`ifdef BRANCH_STATS_EN
    chk32("post_rst stat_br", stat_branches, 32'h1);
    chk32("post_rst stat_mp", stat_mispredicts, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Execute-stage branch resolution unit for the RV32I core.
- Accepts one control-flow instruction per handshake (BRANCH/JAL/JALR) and decodes funct3 into a cmp_op_t. It drives the combinational compare unit with rs1/rs2, then checks the actual outcome against the fetch-stage prediction.
- On a mispredict it issues a held redirect to fetch, then squashes a fixed number of wrong-path slots.
- Sits between the decode/issue register and fetch; also reports the link value for rd writeback.

Parameters:
- XLEN, 32, datapath/address width.
- SQUASH_CYCLES, 2, wrong-path issue slots discarded after a redirect is accepted (1..15).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  unit can accept.
- in_kind  in  2  0=NONE, 1=BRANCH, 2=JAL, 3=JALR (ctl_kind_t).
- in_funct3  in  3  branch funct3.
- in_pc  in  XLEN  instruction PC.
- in_imm  in  XLEN  sign-extended immediate.
- in_rs1  in  XLEN  rs1 value.
- in_rs2  in  XLEN  rs2 value.
- in_pred_taken  in  1  fetch predicted taken.
- in_pred_target  in  XLEN  fetch predicted target.
- res_valid  out  1  one-cycle result pulse.
- res_taken  out  1  actual direction.
- res_link  out  XLEN  pc+4 for JAL/JALR rd.
- res_illegal  out  1  funct3 010/011 on BRANCH.
- res_misalign  out  1  taken target[1:0]!=0.
- redirect_valid  out  1  redirect request, held until accepted.
- redirect_pc  out  XLEN  corrected fetch PC.
- redirect_ready  in  1  fetch accepts redirect.
- squash  out  1  current in_valid is wrong-path.

Behaviour:
- Reset: all outputs 0 except in_ready=1. State=IDLE, squash counter=0.
- Handshake: an instruction is accepted on in_valid&&in_ready. Results are registered, so res_* appear exactly 1 cycle after acceptance.
- res_valid deasserts the next cycle unless another instruction is accepted.
- Decode: funct3 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU. 010/011 sets res_illegal=1, res_taken=0, and no redirect.
- Direction: BRANCH taken = compare result. JAL/JALR are always taken. NONE gives taken=0, and res_valid still pulses.
- Targets: BRANCH/JAL target = pc+imm. JALR target = (rs1+imm)&~1. Fall-through = pc+4. All sums are modulo 2^XLEN (wrap-around, no flag).
- Mispredict: taken!=pred_taken, or taken && target!=pred_target.
- If taken and target[1]=1: res_misalign=1, no redirect, no squash.
- State IDLE:
  - in_ready=1.
  - On an accepted mispredict (not illegal, not misaligned), go to REDIRECT next cycle.
  - In REDIRECT, redirect_valid=1 and redirect_pc = taken ? target : pc+4.
- State REDIRECT:
  - in_ready=0.
  - redirect_valid and redirect_pc stay stable until redirect_ready.
  - On redirect_ready, go to SQUASH with counter=SQUASH_CYCLES.
- State SQUASH:
  - in_ready=1 and squash=1.
  - Every cycle with in_valid=1 consumes the input without evaluation (no res_valid) and decrements the counter.
  - Counter reaching 0 returns to IDLE.
- redirect_ready asserted outside REDIRECT is ignored.
- rst_n low mid-REDIRECT/SQUASH: immediate return to reset values, and any pending redirect is dropped.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined, adds outputs stat_branches[31:0] and stat_mispredicts[31:0]. These are saturating counters of evaluated BRANCH/JAL/JALR instructions and of redirects issued. They reset to 0 and are not incremented for squashed inputs.
- When undefined, the ports and counters are absent.

Decomposition:
- Package types gains:
  - ctl_kind_t;
  - brs_state_t {IDLE, REDIRECT, SQUASH};
  - funct3 constants F3_BEQ..F3_BGEU.
- Reuse the existing cmp_op_t.
- Sub-module branch_op_decode: combinational funct3 to cmp_op_t plus illegal flag.
- The existing compare unit is instantiated as-is.

Test Plan:
- BRANCH BEQ, pc=0x100, imm=0x20, rs1=rs2=5, pred_taken=1, pred_target=0x120 -> res_taken=1, no redirect, in_ready stays 1.
- BRANCH BLT, rs1=0xFFFFFFFF, rs2=1, pred_taken=0, pc=0x200, imm=0x40 -> redirect_pc=0x240. Hold redirect_ready=0 for 3 cycles: redirect_valid/pc stable, in_ready=0. Then accept, and SQUASH_CYCLES=2 inputs are discarded with squash=1.
- BRANCH BGEU, rs1=0x7FFFFFFF, rs2=0x80000000, pred_taken=1, pc=0x300 -> res_taken=0, redirect_pc=0x304.
- JALR, rs1=0x1001, imm=0x2, pc=0x400 -> target 0x1002 flags res_misalign=1, no redirect. With imm=0x3 instead, target=0x1004 and res_link=0x404.
- funct3=010 BRANCH -> res_illegal=1, no redirect. pc=0xFFFFFFFC, imm=8 JAL mispredicted -> redirect_pc=0x00000004.
- Assert rst_n=0 during REDIRECT -> all outputs 0 and in_ready=1 asynchronously. After release, a correctly predicted branch resolves normally.
